// File: rtl/uart_16550_pkg.sv
// uart_16550_pkg: shared UART register layouts and transmitter types.
package uart_16550_pkg;
    typedef struct packed {
        logic       dlab;
        logic       set_break;
        logic       stick;
        logic       eps;
        logic       pen;
        logic       stb;
        logic [1:0] wls;
    } LCR_t;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
    typedef struct packed {
        logic [1:0] wls;
        logic       stb;
        logic       pen;
        logic       eps;
        logic       stick;
    } tx_cfg_t;
    function automatic tx_cfg_t lcr_to_cfg(LCR_t l);
        return '{wls: l.wls, stb: l.stb, pen: l.pen, eps: l.eps, stick: l.stick};
    endfunction
    // Only the bits actually sent (5..8 per wls) contribute to parity
    function automatic logic tx_parity(logic [7:0] d, tx_cfg_t c);
        logic [7:0] md;
        md = d & (8'hFF >> (2'd3 - c.wls));
        return c.stick ? ~c.eps : (c.eps ? ^md : ~^md);
    endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: 16x-oversample tick generator, one tick every div clocks.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    input  logic             restart,
    output logic             tick
);
    logic [DIV_W-1:0] cnt;
    assign tick = (div != '0) && (cnt == '0);
    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= '0;
        else if (div != '0)
            cnt <= (restart || cnt == '0) ? div - DIV_W'(1) : cnt - DIV_W'(1);
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 16550-style transmitter, FIFO or holding register feeding a serial shifter.
module uart_tx_fifo
    import uart_16550_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DIV_W-1:0]            div,
    input  logic [1:0]                  wls,
    input  logic                        stb,
    input  logic                        pen,
    input  logic                        eps,
    input  logic                        stick,
    input  logic                        set_break,
    input  logic                        fifo_en,
    input  logic                        fifo_reset,
    input  logic                        wr_valid,
    input  logic [7:0]                  wr_data,
    output logic                        wr_ready,
    output logic                        txd,
    output logic                        thre,
    output logic                        temt,
    output logic [$clog2(FIFO_DEPTH):0] level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [LW-1:0] level_n;
    tx_state_t     state, state_n;
    tx_cfg_t       cfg, cfg_n, cfg_in;
    logic [7:0]    sh, sh_n;
    logic [2:0]    bcnt, bcnt_n;
    logic [4:0]    tcnt, tcnt_n, stop_last;
    logic          par, par_n, line, line_n;
    logic          tick, push, pop, avail, bit_done, stop_done, load;
    assign cfg_in   = lcr_to_cfg('{dlab: 1'b0, set_break: set_break, stick: stick, eps: eps,
                                   pen: pen, stb: stb, wls: wls});
    assign wr_ready = level < (fifo_en ? LW'(FIFO_DEPTH) : LW'(1));
    assign txd      = line & ~set_break;
    uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clk(clk), .rst(rst), .div(div), .restart(load), .tick(tick)
    );
    always_comb begin
        avail     = (level != '0) && !fifo_reset;
        push      = wr_valid && wr_ready && !fifo_reset;
        stop_last = cfg.stb ? (cfg.wls == 2'b00 ? 5'd23 : 5'd31) : 5'd15;
        bit_done  = tick && tcnt == 5'd15;
        stop_done = state == STOP && tick && tcnt == stop_last;
        load      = avail && ((state == IDLE && div != '0) || stop_done);
        pop       = load;
        state_n   = state;
        cfg_n     = cfg;
        sh_n      = sh;
        bcnt_n    = bcnt;
        par_n     = par;
        tcnt_n    = (tick && state != IDLE) ? tcnt + 5'd1 : tcnt;
        case (state)
            IDLE:    ;
            START:   if (bit_done) begin
                         state_n = DATA;
                         tcnt_n  = '0;
                     end
            DATA:    if (bit_done) begin
                         tcnt_n  = '0;
                         sh_n    = sh >> 1;
                         bcnt_n  = bcnt + 3'd1;
                         state_n = (bcnt == 3'd4 + {1'b0, cfg.wls}) ? (cfg.pen ? PARITY : STOP) : DATA;
                     end
            PARITY:  if (bit_done) begin
                         state_n = STOP;
                         tcnt_n  = '0;
                     end
            STOP:    if (stop_done) begin
                         state_n = IDLE;
                         tcnt_n  = '0;
                     end
            default: state_n = IDLE;
        endcase
        if (load) begin
            state_n = START;
            cfg_n   = cfg_in;
            sh_n    = mem[rp];
            par_n   = tx_parity(mem[rp], cfg_in);
            bcnt_n  = '0;
            tcnt_n  = '0;
        end
        line_n  = state_n == START ? 1'b0 : state_n == DATA ? sh_n[0] : state_n == PARITY ? par_n : 1'b1;
        level_n = fifo_reset ? '0 : level + LW'(push) - LW'(pop);
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            cfg   <= '0;
            sh    <= '0;
            bcnt  <= '0;
            tcnt  <= '0;
            par   <= 1'b0;
            line  <= 1'b1;
            wp    <= '0;
            rp    <= '0;
            level <= '0;
            thre  <= 1'b1;
            temt  <= 1'b1;
        end else begin
            state <= state_n;
            cfg   <= cfg_n;
            sh    <= sh_n;
            bcnt  <= bcnt_n;
            tcnt  <= tcnt_n;
            par   <= par_n;
            line  <= line_n;
            wp    <= fifo_reset ? '0 : wp + AW'(push);
            rp    <= fifo_reset ? '0 : rp + AW'(pop);
            level <= level_n;
            thre  <= level_n == '0;
            temt  <= level_n == '0 && state_n == IDLE;
        end
    always_ff @(posedge clk)
        if (push)
            mem[wp] <= wr_data;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed frame-level checks of the UART transmitter and its FIFO.
module tb_uart_tx_fifo;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] div;
    logic [1:0]  wls;
    logic        stb, pen, eps, stick, set_break, fifo_en, fifo_reset, wr_valid;
    logic [7:0]  wr_data;
    logic        wr_ready, txd, thre, temt;
    logic [4:0]  level;
    logic [7:0]  q [17];
    int          vectors = 0;
    int          miscompares = 0;

    uart_tx_fifo dut (
        .clk(clk), .rst(rst), .div(div), .wls(wls), .stb(stb), .pen(pen), .eps(eps),
        .stick(stick), .set_break(set_break), .fifo_en(fifo_en), .fifo_reset(fifo_reset),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .txd(txd),
        .thre(thre), .temt(temt), .level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_txd(input logic v, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            check(tag, 32'(txd), 32'(v));
            @(negedge clk);
        end
    endtask

    // 8N1 frame with 16-cycle bits at div=1
    task automatic expect_frame(input logic [7:0] d, input int start_n, input int stop_n);
        expect_txd(1'b0, start_n, "start");
        for (int i = 0; i < 8; i++) expect_txd(d[i], 16, "data");
        expect_txd(1'b1, stop_n, "stop");
    endtask

    // Called on the last stop-bit cycle of the final queued character
    task automatic finish_idle();
        check("temt_busy", 32'(temt), 32'd0);
        check("txd_stop", 32'(txd), 32'd1);
        @(negedge clk);
        check("temt_idle", 32'(temt), 32'd1);
        check("txd_idle", 32'(txd), 32'd1);
    endtask

    task automatic send(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic cfg8n1(input logic [15:0] d);
        div = d; wls = 2'b11; stb = 1'b0; pen = 1'b0; eps = 1'b0; stick = 1'b0;
    endtask

    initial begin
        rst = 1'b1; set_break = 1'b0; fifo_en = 1'b1; fifo_reset = 1'b0;
        wr_valid = 1'b0; wr_data = '0;
        cfg8n1(16'd1);
        repeat (2) @(negedge clk);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_thre", 32'(thre), 32'd1);
        check("rst_temt", 32'(temt), 32'd1);
        check("rst_level", 32'(level), 32'd0);
        rst = 1'b0;

        // 8N1 0x55 at div=1
        send(8'h55);
        check("t55_thre_pending", 32'(thre), 32'd0);
        check("t55_level_pending", 32'(level), 32'd1);
        @(negedge clk);
        check("t55_thre_sending", 32'(thre), 32'd1);
        check("t55_temt_sending", 32'(temt), 32'd0);
        expect_frame(8'h55, 16, 15);
        finish_idle();

        // div=2, 5 data bits, even parity, 1.5 stop bits
        div = 16'd2; wls = 2'b00; pen = 1'b1; eps = 1'b1; stb = 1'b1;
        send(8'h1F);
        @(negedge clk);
        expect_txd(1'b0, 32, "t1f_start");
        expect_txd(1'b1, 160, "t1f_data");
        expect_txd(1'b1, 32, "t1f_parity");
        expect_txd(1'b1, 47, "t1f_stop");
        finish_idle();

        // 6 bits stick parity (0), 2 stop bits; LCR changed mid-frame is ignored
        div = 16'd1; wls = 2'b01; pen = 1'b1; eps = 1'b1; stick = 1'b1; stb = 1'b1;
        send(8'hEB);
        @(negedge clk);
        expect_txd(1'b0, 1, "teb_start");
        cfg8n1(16'd1);
        expect_txd(1'b0, 15, "teb_start");
        expect_txd(1'b1, 16, "teb_d0");
        expect_txd(1'b1, 16, "teb_d1");
        expect_txd(1'b0, 16, "teb_d2");
        expect_txd(1'b1, 16, "teb_d3");
        expect_txd(1'b0, 16, "teb_d4");
        expect_txd(1'b1, 16, "teb_d5");
        expect_txd(1'b0, 16, "teb_parity");
        expect_txd(1'b1, 31, "teb_stop");
        finish_idle();

        // Fill 16 entries while stalled, 17th waits for the first pop
        for (int i = 0; i < 17; i++) q[i] = 8'(i * 29 + 7);
        div = 16'd0;
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            wr_data  = q[i];
            @(negedge clk);
        end
        wr_data = q[16];
        check("full_wr_ready", 32'(wr_ready), 32'd0);
        check("full_level", 32'(level), 32'd16);
        check("full_thre", 32'(thre), 32'd0);
        check("full_temt", 32'(temt), 32'd0);
        @(negedge clk);
        check("full_hold_level", 32'(level), 32'd16);
        check("full_hold_txd", 32'(txd), 32'd1);
        div = 16'd1;
        @(negedge clk);
        check("pop_level", 32'(level), 32'd15);
        check("pop_wr_ready", 32'(wr_ready), 32'd1);
        expect_txd(1'b0, 1, "q0_start");
        wr_valid = 1'b0;
        check("refill_level", 32'(level), 32'd16);
        check("refill_wr_ready", 32'(wr_ready), 32'd0);
        expect_frame(q[0], 15, 16);
        for (int i = 1; i < 16; i++) expect_frame(q[i], 16, 16);
        expect_frame(q[16], 16, 15);
        finish_idle();
        check("drain_level", 32'(level), 32'd0);

        // Holding-register mode
        fifo_en = 1'b0;
        send(8'h3C);
        check("hr_wr_ready", 32'(wr_ready), 32'd0);
        check("hr_level", 32'(level), 32'd1);
        check("hr_thre_full", 32'(thre), 32'd0);
        @(negedge clk);
        check("hr_thre_shifting", 32'(thre), 32'd1);
        check("hr_wr_ready_free", 32'(wr_ready), 32'd1);
        check("hr_temt_shifting", 32'(temt), 32'd0);
        expect_txd(1'b0, 1, "hr_start");
        wr_valid = 1'b1;
        wr_data  = 8'hC3;
        expect_txd(1'b0, 1, "hr_start");
        wr_valid = 1'b0;
        check("hr2_level", 32'(level), 32'd1);
        check("hr2_wr_ready", 32'(wr_ready), 32'd0);
        check("hr2_thre", 32'(thre), 32'd0);
        expect_frame(8'h3C, 14, 16);
        expect_frame(8'hC3, 16, 15);
        finish_idle();
        fifo_en = 1'b1;

        // Break across two characters
        wr_valid = 1'b1; wr_data = 8'hFF;
        @(negedge clk);
        wr_data = 8'hFF;
        @(negedge clk);
        wr_data = 8'h81;
        @(negedge clk);
        wr_valid  = 1'b0;
        set_break = 1'b1;
        check("brk_level0", 32'(level), 32'd2);
        for (int i = 0; i < 319; i++) begin
            check("brk_txd", 32'(txd), 32'd0);
            if (i == 158) check("brk_level_pre", 32'(level), 32'd2);
            if (i == 159) check("brk_level_post", 32'(level), 32'd1);
            @(negedge clk);
        end
        set_break = 1'b0;
        check("brk_level_end", 32'(level), 32'd0);
        expect_frame(8'h81, 16, 15);
        finish_idle();

        // fifo_reset wins over a same-cycle write
        div = 16'd0;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i + 1);
            @(negedge clk);
        end
        check("frst_level_pre", 32'(level), 32'd3);
        fifo_reset = 1'b1;
        wr_data    = 8'h77;
        @(negedge clk);
        fifo_reset = 1'b0;
        wr_valid   = 1'b0;
        check("frst_level", 32'(level), 32'd0);
        check("frst_thre", 32'(thre), 32'd1);
        check("frst_temt", 32'(temt), 32'd1);
        div = 16'd1;
        @(negedge clk);
        check("frst_txd", 32'(txd), 32'd1);
        check("frst_level_after", 32'(level), 32'd0);

        // Asynchronous reset in the middle of a data bit
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i * 8'h11);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        check("ar_level", 32'(level), 32'd3);
        repeat (34) @(negedge clk);
        check("ar_txd_data", 32'(txd), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("ar_txd", 32'(txd), 32'd1);
        check("ar_level0", 32'(level), 32'd0);
        check("ar_thre", 32'(thre), 32'd1);
        check("ar_temt", 32'(temt), 32'd1);
        check("ar_wr_ready", 32'(wr_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        send(8'hA5);
        @(negedge clk);
        expect_frame(8'hA5, 16, 15);
        finish_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
